arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised N:1 datapath multiplexer with a registered, valid/ready-handshaked output. It replaces fixed combinational select muxes wherever several producers share one 64-bit consumer, such as writeback sources or shared memory request channels. Two modes are supported: fixed select, which behaves like a classic mux but with flow control, and round-robin arbitration among the valid inputs. The result is held in a single output register stage, so the block adds one cycle of latency and sustains one transfer per cycle.

## Interface
Parameters:
- WIDTH, 64, data bits per channel
- N, 8, number of input channels; power of two, 2..16
- SELW, $clog2(N), width of select/source fields; derived, not overridden

Ports:
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high reset
- in_data  in  [N-1:0][WIDTH-1:0]  per-channel data
- in_valid  in  N  per-channel valid
- in_ready  out  N  per-channel ready; at most one bit high in any cycle
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SELW  channel index used when mode = 0
- out_data  out  WIDTH  registered selected data
- out_src  out  SELW  index of the channel that produced out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts the word

## Operation
- load = !out_valid || out_ready. The output register may take a new word this cycle.
- Grant g is combinational from in_valid, mode, sel and ptr:
  - mode = 0: g = sel if in_valid[sel] = 1, otherwise no grant. Valid bits on the other channels are ignored.
  - mode = 1: g = the first index i with in_valid[i] = 1, searching from (ptr+1) mod N upward and wrapping modulo N. If no input is valid, there is no grant.
- in_ready[g] = load when a grant exists. All other in_ready bits are 0. in_ready is never high for a channel whose in_valid is 0.
- A transfer occurs on channel g when in_valid[g] && in_ready[g]. On a transfer:
  - out_data <= in_data[g]
  - out_src <= g
  - out_valid <= 1
  - ptr <= g; this update happens in both modes
- If load is true but there is no grant: out_valid <= 0; out_data and out_src hold their previous values.
- If load is false (out_valid = 1 and out_ready = 0): all output registers hold, all in_ready are 0, and ptr holds.
- mode and sel are sampled every cycle. A change affects only the next grant and never disturbs a word already held in the output register.
- The round-robin pointer ptr is a SELW-bit register that wraps naturally modulo N. It gives fairness: a continuously valid channel is granted within N transfers.
- Reset values, applied when reset = 1 at a clk edge:
  - out_valid = 0, out_data = 0, out_src = 0
  - ptr = N-1, so channel 0 has first priority after reset
- in_ready is forced to all 0 while reset = 1.
- Reset asserted while a word is held discards that word. No transfer is reported for that cycle.

## Timing
- Latency: an input transfer at edge k makes out_valid = 1 with the data from edge k onward. This is 1 cycle from in_valid/in_ready to output.
- Throughput: 1 word per cycle while out_ready = 1 and some input is granted.
- A simultaneous output drain and input fill (out_valid = 1, out_ready = 1, grant present) is a single-cycle replace with no bubble.
- All outputs are registered except in_ready, which is combinational from in_valid, mode, sel, ptr, out_valid and out_ready.
- in_ready has no combinational dependence on in_data.

## Test plan
- Reset and idle:
  - Stimulus: assert reset for 2 cycles with all in_valid = 1.
  - Required response: out_valid = 0, out_data = 0, out_src = 0 and in_ready = 0 during reset.
  - After release, the first grant goes to channel 0.
- Fixed select sweep:
  - Stimulus: mode = 0, out_ready = 1, random 64-bit data on all 8 channels, all valid; step sel through 0..7, one per cycle.
  - Required response: out_data equals in_data[sel] and out_src equals sel one cycle later. Only in_ready[sel] is high.
- Fixed select with the selected channel idle:
  - Stimulus: mode = 0, sel = 3, in_valid = 8'b1111_0111.
  - Required response: no transfer, in_ready = 0, and out_valid drops to 0 after draining.
- Round-robin fairness:
  - Stimulus: mode = 1, in_valid = 8'b1010_0101 held, out_ready = 1 for 8 cycles.
  - Required response: out_src sequence 0, 2, 5, 7, 0, 2, 5, 7.
- Backpressure:
  - Stimulus: mode = 1, all valid; set out_ready = 0 for 3 cycles after the first word.
  - Required response: out_data, out_src and out_valid hold, in_ready = 0 and ptr is frozen.
  - After release, the next grant is (held out_src + 1) mod 8 with no bubble.
- Mid-operation reset and mode switch:
  - Stimulus: with out_valid = 1, assert reset for 1 cycle; then run mode = 1 for 2 transfers and switch to mode = 0 with sel = 6.
  - Required response: the held word is lost. After the switch, only channel 6 is granted, and ptr = 6 after its transfer.

Source files
------------

// File: rtl/arb_mux.sv
// arb_mux: N:1 datapath multiplexer with a single registered output stage.
// Mode 0 forwards a fixed, externally selected channel; mode 1 arbitrates
// round-robin among the valid channels. Adds one cycle of latency and
// sustains one transfer per cycle, including drain-and-refill in one cycle.
//
// Handshake: a word moves across an interface on a rising clk edge where
// both valid and ready are high. Valid never waits on ready. On the input
// side, in_ready is raised for at most the one granted channel, and only
// when that channel is valid and the output register can accept a word.
// On the output side, out_valid stays high and out_data/out_src stay
// stable until the consumer raises out_ready.

module arb_mux #(
    parameter int  WIDTH = 64,
    parameter int  N     = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0][WIDTH-1:0]   in_data,
    input  logic [N-1:0]              in_valid,
    output logic [N-1:0]              in_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_src,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Round-robin pointer: the most recently granted channel. The search
    // for the next grant starts one past it, so it resets to N-1 to give
    // channel 0 first priority.
    logic [SELW-1:0] ptr;

    // Grant decision for this cycle.
    logic            gnt_valid;
    logic [SELW-1:0] gnt_idx;
    logic [SELW-1:0] cand;

    // Output register can take a new word when empty or being drained.
    logic load;

    // A transfer really happens this cycle (reset suppresses it).
    logic take;

    assign load = !out_valid || out_ready;
    assign take = gnt_valid && load && !reset;

    // Grant selection: fixed select, or first valid channel after ptr.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        if (!mode) begin
            // Other channels' valid bits are deliberately ignored here.
            if (in_valid[sel]) begin
                gnt_valid = 1'b1;
                gnt_idx   = sel;
            end
        end else begin
            // Offsets 1..N from ptr; offset N wraps back to ptr itself, so a
            // channel that is the only valid one can be granted repeatedly.
            for (int k = 1; k <= N; k++) begin
                cand = ptr + SELW'(k);
                if (!gnt_valid && in_valid[cand]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    // One-hot ready towards the granted channel only; independent of data.
    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SELW'(N - 1);
        end else if (load) begin
            if (gnt_valid) begin
                out_data  <= in_data[gnt_idx];
                out_src   <= gnt_idx;
                out_valid <= 1'b1;
                // Pointer follows grants in both modes so a later switch to
                // round-robin continues fairly from the last served channel.
                ptr       <= gnt_idx;
            end else begin
                // Nothing to load: the word (if any) was drained; keep the
                // stale data/src but mark the register empty.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Testbench for arb_mux: directed phases with hand-computed literal checks,
// a short randomized tail, and a per-cycle reference model comparison.

module tb_arb_mux;

  localparam int WIDTH = 64;
  localparam int N     = 8;
  localparam int SELW  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic                    mode;
  logic [SELW-1:0]         sel;
  logic [WIDTH-1:0]        out_data;
  logic [SELW-1:0]         out_src;
  logic                    out_valid;
  logic                    out_ready;

  arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [SELW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Output register contents and "last served channel" as plain integers.
  logic              m_valid = 1'b0;
  logic [WIDTH-1:0]  m_data  = '0;
  int                m_src   = 0;
  int                m_last  = N - 1;

  // Which channel the rules grant right now, or -1 for none.
  function automatic int pick();
    if (mode == 1'b0) begin
      return in_valid[sel] ? int'(sel) : -1;
    end
    for (int d = 1; d <= N; d++) begin
      int c;
      c = (m_last + d) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    logic [N-1:0] r;
    r = '0;
    g = pick();
    if (!reset && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Model advances on the same edge as the DUT; inputs change only at +1.
  always @(posedge clk) begin
    int g;
    if (reset) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_last  = N - 1;
    end else if (!m_valid || out_ready) begin
      g = pick();
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g];
        m_src   = g;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    chk("m_out_valid", 64'(out_valid), 64'(m_valid));
    chk("m_out_src",   64'(out_src),   64'(m_src));
    chk("m_out_data",  out_data,       m_data);
    chk("m_in_ready",  64'(in_ready),  64'(model_ready()));
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic md, input logic [SELW-1:0] s,
                       input logic ordy);
    in_valid  = v;
    mode      = md;
    sel       = s;
    out_ready = ordy;
    #1;
  endtask

  task automatic new_data();
    for (int i = 0; i < N; i++) in_data[i] = {$urandom, $urandom};
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [WIDTH-1:0] held;

    reset = 1'b1;
    new_data();
    in_valid  = '1;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;

    // Reset and idle: all valid, reset for two edges.
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_out_src",   64'(out_src),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    reset = 1'b0;
    drive(8'hFF, 1'b1, 3'd0, 1'b1);
    chk("first_ready", 64'(in_ready), 64'h01);
    tick();
    chk("first_src", 64'(out_src), 64'd0);
    chk("first_data", out_data, in_data[0]);

    // Fixed select sweep.
    new_data();
    for (int s = 0; s < N; s++) begin
      drive(8'hFF, 1'b0, 3'(s), 1'b1);
      chk("sweep_ready", 64'(in_ready), 64'(1) << s);
      tick();
      chk("sweep_src",  64'(out_src), 64'(s));
      chk("sweep_data", out_data, in_data[s]);
    end

    // Fixed select, selected channel idle: output drains and empties.
    drive(8'b1111_0111, 1'b0, 3'd3, 1'b1);
    chk("idle_ready", 64'(in_ready), 64'd0);
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // Round-robin fairness over a sparse valid pattern (last grant was 7).
    new_data();
    drive(8'b1010_0101, 1'b1, 3'd0, 1'b1);
    exp_q = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2, 3'd5, 3'd7};
    while (exp_q.size() > 0) begin
      logic [SELW-1:0] e;
      e = exp_q.pop_front();
      tick();
      chk("rr_src", 64'(out_src), 64'(e));
    end

    // Backpressure: first word is channel 0, then hold for three cycles.
    drive(8'hFF, 1'b1, 3'd0, 1'b1);
    tick();
    chk("bp_first_src", 64'(out_src), 64'd0);
    held = in_data[0];
    drive(8'hFF, 1'b1, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 64'(in_ready), 64'd0);
      new_data();
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_src",   64'(out_src),   64'd0);
      chk("bp_data",  out_data,       held);
    end
    drive(8'hFF, 1'b1, 3'd0, 1'b1);
    chk("bp_release_ready", 64'(in_ready), 64'h02);
    tick();
    chk("bp_release_src",   64'(out_src),   64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd1);

    // Mid-operation reset with a held word.
    drive(8'hFF, 1'b1, 3'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    drive(8'hFF, 1'b1, 3'd0, 1'b1);
    tick();
    chk("mid_rr0", 64'(out_src), 64'd0);
    tick();
    chk("mid_rr1", 64'(out_src), 64'd1);
    drive(8'hFF, 1'b0, 3'd6, 1'b1);
    chk("sw_ready", 64'(in_ready), 64'h40);
    tick();
    chk("sw_src",  64'(out_src), 64'd6);
    chk("sw_data", out_data,     in_data[6]);
    // Pointer now 6: round-robin resumes at channel 7.
    drive(8'hFF, 1'b1, 3'd0, 1'b1);
    chk("sw_ptr_ready", 64'(in_ready), 64'h80);
    tick();
    chk("sw_ptr_src", 64'(out_src), 64'd7);

    // Randomized tail, checked by the model each cycle.
    for (int i = 0; i < 300; i++) begin
      new_data();
      reset = ($urandom_range(0, 40) == 0);
      drive(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      tick();
    end

    reset = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
